// File: rtl/alu_pkg.sv
// Shared ALUOp encodings, default operand width and the arbiter's result-register state type.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_SLT = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0111;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
   parameter int XLEN = alu_pkg::XLEN_DEFAULT
);
   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic signed [XLEN-1:0] req0_a;
   logic signed [XLEN-1:0] req0_b;
   logic signed [XLEN-1:0] req1_a;
   logic signed [XLEN-1:0] req1_b;
   logic [3:0]             req0_op;
   logic [3:0]             req1_op;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_id;
   logic signed [XLEN-1:0] rsp_data;

   modport master (
      output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: wrap-around add/sub, signed set-less-than, bitwise or/and; unknown ops yield 0.
module alu
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic signed [XLEN-1:0] A,
   input  logic signed [XLEN-1:0] B,
   input  logic [3:0]             ALUOp,
   output logic signed [XLEN-1:0] ALURes
);
   always_comb begin
      ALURes = '0;
      case (ALUOp)
         ALU_ADD: ALURes = A + B;
         ALU_SUB: ALURes = A - B;
         ALU_SLT: ALURes = {{(XLEN-1){1'b0}}, (A < B)};
         ALU_OR:  ALURes = A | B;
         ALU_AND: ALURes = A & B;
         default: ALURes = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU behind a single registered result slot.
// ALU_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);
   state_t                 state_p1;
   state_t                 state_nxt;
   logic                   grant_ok_p0;
   logic [1:0]             grant_p0;
   logic                   accept_p0;
   logic                   sel_p0;
   logic signed [XLEN-1:0] a_p0;
   logic signed [XLEN-1:0] b_p0;
   logic [3:0]             op_p0;
   logic signed [XLEN-1:0] res_p0;
   logic signed [XLEN-1:0] data_p1;
   logic                   id_p1;

   // The slot can take a new result when empty, or when it drains in this same cycle.
   assign grant_ok_p0 = rst_n && ((state_p1 == EMPTY) || bus.rsp_ready);

`ifdef ALU_ARB_RR_EN
   logic prio_p1;

   always_comb begin
      grant_p0 = 2'b00;
      if (grant_ok_p0) begin
         case (bus.req_valid)
            2'b01:   grant_p0 = 2'b01;
            2'b10:   grant_p0 = 2'b10;
            2'b11:   grant_p0 = prio_p1 ? 2'b10 : 2'b01;
            default: grant_p0 = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         prio_p1 <= 1'b0;
      else if (accept_p0) prio_p1 <= ~sel_p0;
   end
`else
   always_comb begin
      grant_p0 = 2'b00;
      if (grant_ok_p0) begin
         if (bus.req_valid[0])      grant_p0 = 2'b01;
         else if (bus.req_valid[1]) grant_p0 = 2'b10;
      end
   end
`endif

   assign accept_p0 = |grant_p0;
   assign sel_p0    = grant_p0[1];

   assign a_p0  = sel_p0 ? bus.req1_a  : bus.req0_a;
   assign b_p0  = sel_p0 ? bus.req1_b  : bus.req0_b;
   assign op_p0 = sel_p0 ? bus.req1_op : bus.req0_op;

   alu #(.XLEN(XLEN)) u_alu (
      .A      (a_p0),
      .B      (b_p0),
      .ALUOp  (op_p0),
      .ALURes (res_p0)
   );

   always_comb begin
      state_nxt = state_p1;
      case (state_p1)
         EMPTY:   if (accept_p0) state_nxt = FULL;
         FULL:    if (!accept_p0 && bus.rsp_ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // p0 -> p1: register the ALU result and its owner on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= EMPTY;
         data_p1  <= '0;
         id_p1    <= 1'b0;
      end else begin
         state_p1 <= state_nxt;
         if (accept_p0) begin
            data_p1 <= res_p0;
            id_p1   <= sel_p0;
         end
      end
   end

   assign bus.req_ready = grant_p0;
   assign bus.rsp_valid = (state_p1 == FULL);
   assign bus.rsp_id    = id_p1;
   assign bus.rsp_data  = data_p1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus backpressure, reset and contention sequences.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   alu_arbiter_if #(.XLEN(32)) bus ();

   alu_arbiter #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive_req(input logic id, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
         bus.req0_op = ALU_ADD; bus.req0_a = 32'h5555; bus.req0_b = 32'h1;
      end else begin
         bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
         bus.req1_op = ALU_SUB; bus.req1_a = 32'h7777; bus.req1_b = 32'h2;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_rdy;
      logic       exp_id;
      pass_cnt  = 0;
      total_cnt = 0;

      vecs[0] = '{1'b0, ALU_ADD, 32'd10,        32'd5,        32'd15};
      vecs[1] = '{1'b1, ALU_SUB, 32'd10,        32'd5,        32'd5};
      vecs[2] = '{1'b0, ALU_SLT, 32'hFFFFFFFF,  32'd1,        32'd1};
      vecs[3] = '{1'b1, ALU_SLT, 32'd20,        32'd10,       32'd0};
      vecs[4] = '{1'b0, ALU_ADD, 32'h7FFFFFFF,  32'd1,        32'h80000000};
      vecs[5] = '{1'b1, ALU_OR,  32'hF0F0F0F0,  32'h0F0F0F0F, 32'hFFFFFFFF};
      vecs[6] = '{1'b0, ALU_AND, 32'hFF00FF00,  32'h0FF00FF0, 32'h0F000F00};
      vecs[7] = '{1'b1, 4'b1111, 32'h12345678,  32'h9ABCDEF0, 32'h0};

      // Reset state, with requests pending
      rst_n         = 1'b0;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      drive_req(1'b0, ALU_ADD, 32'd1, 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_id",    {31'b0, bus.rsp_id},    32'd0);
      check("rst_rsp_data",  bus.rsp_data,           32'd0);
      check("rst_req_ready", {30'b0, bus.req_ready}, 32'd0);
      rst_n         = 1'b1;
      bus.req_valid = 2'b00;
      @(negedge clk);

      // Vector table: single requester, consumer always ready
      for (int i = 0; i < 8; i++) begin
         drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
         bus.req_valid = vecs[i].id ? 2'b10 : 2'b01;
         exp_rdy       = vecs[i].id ? 2'b10 : 2'b01;
         #1;
         check($sformatf("vec%0d_req_ready", i), {30'b0, bus.req_ready}, {30'b0, exp_rdy});
         @(negedge clk);
         check($sformatf("vec%0d_rsp_valid", i), {31'b0, bus.rsp_valid}, 32'd1);
         check($sformatf("vec%0d_rsp_id", i),    {31'b0, bus.rsp_id},    {31'b0, vecs[i].id});
         check($sformatf("vec%0d_rsp_data", i),  bus.rsp_data,           vecs[i].res);
      end
      bus.req_valid = 2'b00;
      @(negedge clk);
      check("drain_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

      // Backpressure: OR result must hold while the consumer stalls
      bus.rsp_ready = 1'b0;
      drive_req(1'b1, ALU_OR, 32'hF0F0F0F0, 32'h0F0F0F0F);
      bus.req_valid = 2'b10;
      #1;
      check("bp_first_ready", {30'b0, bus.req_ready}, 32'd2);
      @(negedge clk);
      drive_req(1'b0, ALU_ADD, 32'd2, 32'd2);
      bus.req_valid = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp%0d_req_ready", c), {30'b0, bus.req_ready}, 32'd0);
         check($sformatf("bp%0d_rsp_valid", c), {31'b0, bus.rsp_valid}, 32'd1);
         check($sformatf("bp%0d_rsp_id", c),    {31'b0, bus.rsp_id},    32'd1);
         check($sformatf("bp%0d_rsp_data", c),  bus.rsp_data,           32'hFFFFFFFF);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", {30'b0, bus.req_ready}, 32'd1);
      @(negedge clk);
      check("bp_next_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("bp_next_id",    {31'b0, bus.rsp_id},    32'd0);
      check("bp_next_data",  bus.rsp_data,           32'd4);
      bus.req_valid = 2'b00;
      @(negedge clk);

      // Reset while FULL after a grant to requester 0
      bus.rsp_ready = 1'b0;
      drive_req(1'b0, ALU_ADD, 32'd7, 32'd1);
      bus.req_valid = 2'b01;
      @(negedge clk);
      check("mid_full_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("mid_full_data",  bus.rsp_data,           32'd8);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("mid_rst_data",  bus.rsp_data,           32'd0);
      check("mid_rst_ready", {30'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention every cycle, consumer always ready
      bus.rsp_ready = 1'b1;
      bus.req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         bus.req0_op = ALU_ADD; bus.req0_a = i; bus.req0_b = 32'd1;
         bus.req1_op = ALU_SUB; bus.req1_a = 32'd100; bus.req1_b = i;
`ifdef ALU_ARB_RR_EN
         exp_id = i[0];
`else
         exp_id = 1'b0;
`endif
         #1;
         check($sformatf("cont%0d_req_ready", i), {30'b0, bus.req_ready},
               exp_id ? 32'd2 : 32'd1);
         @(negedge clk);
         check($sformatf("cont%0d_rsp_id", i),   {31'b0, bus.rsp_id}, {31'b0, exp_id});
         check($sformatf("cont%0d_rsp_data", i), bus.rsp_data,
               exp_id ? (32'd100 - i) : (i + 32'd1));
      end
      bus.req_valid = 2'b00;
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester grant; a request transfers when req_valid[i] and req_ready[i] are both high on a rising edge.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  XLEN each  signed operands for requester 0 and requester 1.
REQ-007 req0_op, req1_op  input  4  ALUOp per requester, using the alu_pkg encodings.
REQ-008 rsp_valid  output  1  registered result valid.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-011 rsp_data  output  XLEN  registered ALU result.

Function
REQ-012 The block SHALL share one ALU instance between two requesters, with one transfer per cycle maximum.
REQ-013 States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-014 At most one req_ready bit SHALL be high in any cycle, and req_ready SHALL be 0 for any requester whose req_valid is 0.
REQ-015 A grant SHALL be issued when the state is EMPTY, or when the state is FULL and rsp_ready=1 in the same cycle (pass-through drain).
REQ-016 An accepted request SHALL appear on rsp_data/rsp_id with rsp_valid=1 exactly one cycle after acceptance, giving 1-cycle latency.
REQ-017 Transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept, or on no rsp_ready.
REQ-018 While FULL and rsp_ready=0, rsp_data and rsp_id SHALL hold stable and req_ready SHALL be 2'b00.
REQ-019 Arbitration (see Configuration) SHALL be evaluated only on cycles where a grant is possible; the priority pointer SHALL advance only on an accepted transfer.
REQ-020 Only one requester valid: that requester SHALL be granted regardless of pointer.
REQ-021 Results SHALL be computed at full XLEN width with wrap-around (no overflow flag); SLT SHALL compare signed and return 0 or 1.
REQ-022 An unrecognised ALUOp SHALL produce rsp_data=0 and still complete the handshake.

Reset
REQ-023 rst_n low SHALL asynchronously force rsp_valid=0, rsp_id=0, rsp_data=0, priority pointer=0 (requester 0 first), state EMPTY.
REQ-024 req_ready SHALL be 2'b00 while rst_n is low; a result held in the register at reset mid-operation SHALL be discarded.
REQ-025 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro ALU_ARB_RR_EN defined: round-robin; after a grant to i, requester 1-i has priority on the next contention.
REQ-027 Macro ALU_ARB_RR_EN undefined: fixed priority, with requester 0 always winning contention; the pointer register SHALL NOT be synthesised.

Structure
REQ-028 Package alu_pkg SHALL hold the ALUOp constants ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLT=4'b0010, ALU_OR=4'b0110, ALU_AND=4'b0111, plus the XLEN default.
REQ-029 The block SHALL instantiate the existing ALU module (ports A, B, ALUOp, ALURes) as its single sub-module, fed from a combinational operand mux.

Verification
REQ-030 Requester 0 only: 10 ADD 5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=15.
REQ-031 Both valid every cycle, rsp_ready=1, with ALU_ARB_RR_EN -> grants alternate 0,1,0,1; with ALU_ARB_RR_EN undefined -> always 0.
REQ-032 Backpressure: requester 1 issues 32'hF0F0F0F0 OR 32'h0F0F0F0F with rsp_ready=0 for 3 cycles -> rsp_data=32'hFFFFFFFF holds, req_ready=0, and a new request is accepted in the cycle rsp_ready rises.
REQ-033 Signed and wrap cases: SLT -1 vs 1 -> 1; SLT 20 vs 10 -> 0; ADD 32'h7FFFFFFF+1 -> 32'h80000000; SUB 10-5 -> 5.
REQ-034 Reset mid-operation: assert rst_n low while FULL -> rsp_valid drops immediately without waiting for a clock edge; after release the first contention is granted to requester 0.
REQ-035 Op 4'b1111 -> rsp_data=0, rsp_valid=1, handshake completes normally.
